// File: rtl/matcher_filter_pkg.sv
// Shared types and width helpers for the filter-list stream matcher.
package matcher_filter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int addr_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic int cnt_w(input int len);
        return $clog2(len) + 1;
    endfunction

    // Result record is packed as {mask, data, index}, index in the LSBs.
    function automatic int rec_w(input int nb, input int dw, input int aw);
        return nb + dw + aw;
    endfunction

endpackage

// File: rtl/matcher_filter_scan_if.sv
// Stream, BRAM and result-readout signals of the matcher; slave = matcher side.
interface matcher_filter_scan_if #(
    parameter int INPUT_STREAM_WIDTH = 512,
    parameter int DATA_WIDTH         = 24,
    parameter int FILTER_LENGTH      = 128
);
    import matcher_filter_pkg::*;

    localparam int AW   = addr_w(FILTER_LENGTH);
    localparam int CNTW = cnt_w(FILTER_LENGTH);

    logic [CNTW-1:0]                 filter_count;
    logic [INPUT_STREAM_WIDTH-1:0]   input_stream;
    logic                            data_valid;
    logic                            data_ready;
    logic                            mem_enable;
    logic [AW-1:0]                   mem_addr;
    logic [DATA_WIDTH-1:0]           mem_data_out;
    logic [INPUT_STREAM_WIDTH/8-1:0] filter_result;
    logic [DATA_WIDTH-1:0]           filter_result_data;
    logic [AW-1:0]                   filter_result_index;
    logic                            filter_result_valid;
    logic                            filter_result_ready;
    logic                            filter_result_done;
    logic [CNTW-1:0]                 match_count;

    modport slave (
        input  filter_count, input_stream, data_valid, mem_data_out, filter_result_ready,
        output data_ready, mem_enable, mem_addr, filter_result, filter_result_data,
               filter_result_index, filter_result_valid, filter_result_done, match_count
    );

    modport master (
        output filter_count, input_stream, data_valid, mem_data_out, filter_result_ready,
        input  data_ready, mem_enable, mem_addr, filter_result, filter_result_data,
               filter_result_index, filter_result_valid, filter_result_done, match_count
    );

endinterface

// File: rtl/matcher_result_fifo.sv
// Synchronous result FIFO with occupancy count; head output forced to 0 while empty.
module matcher_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_pop, do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_C) || do_pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/matcher_filter_scan.sv
// Captures one input word, scans a BRAM filter list and queues every hit with its index.
// Optional MATCHER_FILTER_ENTRY_MASK_EN: entry top bits carry a per-byte key-enable mask.
module matcher_filter_scan
    import matcher_filter_pkg::*;
#(
    parameter int INPUT_STREAM_WIDTH = 512,
    parameter int COMPARE_WIDTH      = 16,
    parameter int FILTER_LENGTH      = 128,
    parameter int DATA_WIDTH         = 24,
    parameter int RESULT_FIFO_DEPTH  = 4
) (
    input  logic                  fclk,
    input  logic                  areset,
    matcher_filter_scan_if.slave  bus
);
    localparam int NB     = INPUT_STREAM_WIDTH / 8;
    localparam int KB     = COMPARE_WIDTH / 8;
    localparam int MAXOFF = NB - KB;
    localparam int AW     = addr_w(FILTER_LENGTH);
    localparam int CNTW   = cnt_w(FILTER_LENGTH);
    localparam int RECW   = rec_w(NB, DATA_WIDTH, AW);
    localparam int FCW    = $clog2(RESULT_FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0] FL_C    = CNTW'(FILTER_LENGTH);
    localparam logic [FCW-1:0]  DEPTH_C = FCW'(RESULT_FIFO_DEPTH);

    state_t                        state_q, state_d;
    logic [AW-1:0]                 addr_q, addr_d;
    logic [CNTW-1:0]               cnt_q;
    logic [CNTW-1:0]               hit_q;
    logic [CNTW-1:0]               match_q;
    logic                          s1_vld_q;
    logic [AW-1:0]                 s1_idx_q;
    logic [INPUT_STREAM_WIDTH-1:0] snap_q;

    logic            accept, issue, issue_ok, last_addr, push;
    logic [KB-1:0]   key_en;
    logic [NB-1:0]   hit_mask;
    logic [RECW-1:0] head;
    logic [FCW-1:0]  fifo_count;

    function automatic logic [CNTW-1:0] clamp_count(input logic [CNTW-1:0] c);
        return (c > FL_C) ? FL_C : c;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v >= FL_C) ? FL_C : v + 1'b1;
    endfunction

    // Disabled key bytes compare as equal; an all-zero enable never hits.
    function automatic logic [NB-1:0] key_hits(input logic [INPUT_STREAM_WIDTH-1:0] word,
                                               input logic [COMPARE_WIDTH-1:0]      key,
                                               input logic [KB-1:0]                 en);
        logic [NB-1:0] m;
        logic          eq;
        m = '0;
        for (int i = 0; i <= MAXOFF; i++) begin
            eq = |en;
            for (int b = 0; b < KB; b++)
                if (en[b] && (word[8*(i+b) +: 8] != key[8*b +: 8])) eq = 1'b0;
            m[i] = eq;
        end
        return m;
    endfunction

`ifdef MATCHER_FILTER_ENTRY_MASK_EN
    assign key_en = bus.mem_data_out[DATA_WIDTH-1 -: KB];
`else
    assign key_en = '1;
`endif

    // Issue only if the FIFO can absorb the in-flight entry plus this one.
    assign issue_ok  = (fifo_count + FCW'(s1_vld_q)) < DEPTH_C;
    assign last_addr = (CNTW'(addr_q) == (cnt_q - 1'b1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    accept  = 1'b1;
                    addr_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else if (issue_ok) begin
                    issue = 1'b1;
                    if (last_addr) state_d = DRAIN;
                    else           addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN:   if (!s1_vld_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            hit_q    <= '0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            s1_vld_q <= issue;
            if (accept) cnt_q <= clamp_count(bus.filter_count);
            if (accept)    hit_q <= '0;
            else if (push) hit_q <= sat_inc(hit_q);
            if (state_q == DRAIN && !s1_vld_q) match_q <= hit_q;
        end
    end

    always_ff @(posedge fclk) begin
        if (accept) snap_q   <= bus.input_stream;
        if (issue)  s1_idx_q <= addr_q;
    end

    // Stage 1: BRAM word arrives, compare at every legal byte offset and queue hits.
    assign hit_mask = key_hits(snap_q, bus.mem_data_out[COMPARE_WIDTH-1:0], key_en);
    assign push     = s1_vld_q && (|hit_mask);

    matcher_result_fifo #(
        .WIDTH (RECW),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (fclk),
        .rst_i   (areset),
        .push_i  (push),
        .data_i  ({hit_mask, bus.mem_data_out, s1_idx_q}),
        .pop_i   (bus.filter_result_ready),
        .data_o  (head),
        .valid_o (bus.filter_result_valid),
        .count_o (fifo_count)
    );

    assign bus.data_ready          = (state_q == IDLE);
    assign bus.mem_enable          = issue;
    assign bus.mem_addr            = addr_q;
    assign bus.filter_result       = head[RECW-1 -: NB];
    assign bus.filter_result_data  = head[AW +: DATA_WIDTH];
    assign bus.filter_result_index = head[AW-1:0];
    assign bus.filter_result_done  = (state_q == DONE);
    assign bus.match_count         = match_q;

endmodule

// File: tb/tb_matcher_filter_scan.sv
// Bench for matcher_filter_scan: vector table plus stall, clamp, top-offset and reset sequences.
module tb_matcher_filter_scan;

    typedef struct {
        int          cnt;
        logic [7:0]  fill;
        int          off;
        int          idx;
        logic [15:0] key;
        int          hits;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [63:0] mask;
        logic [23:0] data;
        logic [6:0]  idx;
    } res_t;

    logic fclk = 1'b0;
    logic areset;
    logic [23:0] bram [128];
    res_t sb [$];
    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [6];

    matcher_filter_scan_if #(.INPUT_STREAM_WIDTH(512), .DATA_WIDTH(24), .FILTER_LENGTH(128)) bus ();

    matcher_filter_scan dut (
        .fclk   (fclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 fclk = ~fclk;

    always @(posedge fclk) begin
        if (bus.mem_enable) bus.mem_data_out <= bram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_mask(input logic [511:0] w, input logic [23:0] e);
        logic [63:0] m;
        logic [1:0]  en;
        logic        lo_ok, hi_ok;
        m = '0;
`ifdef MATCHER_FILTER_ENTRY_MASK_EN
        en = e[23:22];
`else
        en = 2'b11;
`endif
        for (int i = 0; i < 63; i++) begin
            lo_ok = !en[0] || (w[8*i +: 8] == e[7:0]);
            hi_ok = !en[1] || (w[8*i+8 +: 8] == e[15:8]);
            m[i]  = (en != 2'b00) && lo_ok && hi_ok;
        end
        return m;
    endfunction

    always @(negedge fclk) begin
        if (!areset && bus.filter_result_valid && bus.filter_result_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got index %0d, none expected", bus.filter_result_index);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("res_mask",  64'(bus.filter_result), e.mask);
                check("res_data",  64'(bus.filter_result_data), 64'(e.data));
                check("res_index", 64'(bus.filter_result_index), 64'(e.idx));
            end
        end
    end

    task automatic load_background();
        for (int i = 0; i < 128; i++) bram[i] = {2'b11, 6'(i), 16'h1100 | 16'(i)};
    endtask

    task automatic start_packet(input int cnt, input logic [511:0] word);
        int t;
        int eff;
        logic [63:0]  m;
        logic [511:0] rnd;
        t = 0;
        while (!bus.data_ready && t < 500) begin
            @(posedge fclk); #1;
            t++;
        end
        check("ready_before_accept", 64'(bus.data_ready), 64'd1);
        eff = (cnt > 128) ? 128 : cnt;
        for (int i = 0; i < eff; i++) begin
            m = model_mask(word, bram[i]);
            if (m != '0) sb.push_back('{m, bram[i], 7'(i)});
        end
        bus.filter_count = 8'(cnt);
        bus.input_stream = word;
        bus.data_valid   = 1'b1;
        @(posedge fclk); #1;
        for (int k = 0; k < 16; k++) rnd[32*k +: 32] = $urandom();
        bus.data_valid   = 1'b0;
        bus.input_stream = rnd;
        bus.filter_count = 8'($urandom());
    endtask

    task automatic wait_done(input int exp_lat, input int exp_hits, input string tag);
        int c;
        bit seen;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 3000) begin
            @(posedge fclk); #1;
            c++;
            if (bus.filter_result_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(c), 64'(exp_lat));
        check({tag, "_match_count"}, 64'(bus.match_count), 64'(exp_hits));
        @(posedge fclk); #1;
        check({tag, "_done_pulse"}, 64'(bus.filter_result_done), 64'd0);
        check({tag, "_match_held"}, 64'(bus.match_count), 64'(exp_hits));
    endtask

    task automatic drain_sb(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge fclk); #1;
            t++;
        end
        check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [511:0] w;
        load_background();
        bram[v.idx] = {2'b11, 6'(v.idx), v.key};
        for (int b = 0; b < 64; b++) w[8*b +: 8] = v.fill;
        if (v.off >= 0) w[8*v.off +: 16] = 16'hABCD;
        start_packet(v.cnt, w);
        wait_done(v.lat, v.hits, tag);
        drain_sb(tag);
    endtask

    initial begin
        logic [511:0] w;
        //         cnt  fill   off idx  key       hits lat
        vecs[0] = '{8,   8'h00, 2,  5,   16'hABCD, 1,   10};
        vecs[1] = '{0,   8'h00, 2,  5,   16'hABCD, 0,   2};
        vecs[2] = '{8,   8'h00, 62, 0,   16'hABCD, 1,   10};
        vecs[3] = '{5,   8'h00, 10, 5,   16'hABCD, 0,   7};
        vecs[4] = '{200, 8'h00, 30, 127, 16'hABCD, 1,   130};
        vecs[5] = '{4,   8'hCD, -1, 3,   16'hCDCD, 1,   6};

        areset = 1'b1;
        bus.filter_count = '0;
        bus.input_stream = '0;
        bus.data_valid = 1'b0;
        bus.filter_result_ready = 1'b1;
        bus.mem_data_out = '0;
        load_background();
        repeat (3) @(posedge fclk);
        #1;
        check("rst_data_ready",   64'(bus.data_ready), 64'd1);
        check("rst_mem_enable",   64'(bus.mem_enable), 64'd0);
        check("rst_mem_addr",     64'(bus.mem_addr), 64'd0);
        check("rst_result_valid", 64'(bus.filter_result_valid), 64'd0);
        check("rst_result",       64'(bus.filter_result), 64'd0);
        check("rst_done",         64'(bus.filter_result_done), 64'd0);
        check("rst_match_count",  64'(bus.match_count), 64'd0);
        areset = 1'b0;
        @(posedge fclk); #1;

        for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Back-pressure: six hits, consumer stalled.
        load_background();
        for (int i = 0; i < 6; i++) bram[i] = {2'b11, 6'(i), 16'hABCD};
        w = '0;
        w[8*4 +: 16] = 16'hABCD;
        bus.filter_result_ready = 1'b0;
        start_packet(6, w);
        repeat (20) @(posedge fclk);
        #1;
        check("stall_mem_enable", 64'(bus.mem_enable), 64'd0);
        check("stall_mem_addr",   64'(bus.mem_addr), 64'd4);
        check("stall_valid",      64'(bus.filter_result_valid), 64'd1);
        check("stall_head_index", 64'(bus.filter_result_index), 64'd0);
        check("stall_head_mask",  64'(bus.filter_result), 64'h10);
        check("stall_done",       64'(bus.filter_result_done), 64'd0);
        bus.filter_result_ready = 1'b1;
        wait_done(-1, 6, "stall");
        drain_sb("stall");

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < 128; i++) bram[i] = {2'b11, 6'(i), 16'hABCD};
        bus.filter_result_ready = 1'b0;
        start_packet(128, w);
        repeat (3) @(posedge fclk);
        #3;
        areset = 1'b1;
        #1;
        check("arst_data_ready",   64'(bus.data_ready), 64'd1);
        check("arst_mem_enable",   64'(bus.mem_enable), 64'd0);
        check("arst_mem_addr",     64'(bus.mem_addr), 64'd0);
        check("arst_result_valid", 64'(bus.filter_result_valid), 64'd0);
        check("arst_result_index", 64'(bus.filter_result_index), 64'd0);
        check("arst_match_count",  64'(bus.match_count), 64'd0);
        sb.delete();
        @(posedge fclk); #1;
        areset = 1'b0;
        bus.filter_result_ready = 1'b1;
        run_vec(vecs[0], "post_rst");

`ifdef MATCHER_FILTER_ENTRY_MASK_EN
        load_background();
        bram[0] = {2'b01, 6'd0, 16'h00CD};
        bram[1] = {2'b00, 6'd1, 16'hABCD};
        bram[2] = {2'b10, 6'd2, 16'hAB00};
        w = '0;
        w[8*2 +: 16] = 16'hABCD;
        w[8*7 +: 16] = 16'h5ACD;
        start_packet(3, w);
        wait_done(5, 2, "bytemask");
        drain_sb("bytemask");
`endif

        drain_sb("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
